// File: rtl/rsa_modexp_pkg.sv
// Shared types for the modular exponentiation engine and its Montgomery multiplier.
package rsa_modexp_pkg;

  localparam int unsigned NDefault     = 512;
  localparam int unsigned ElenWDefault = 10;

  typedef enum logic [3:0] {
    StIdle,
    StPre,
    StPreWait,
    StSq,
    StSqWait,
    StMul,
    StMulWait,
    StLoopChk,
    StPost,
    StPostWait,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    SelXR2,
    SelAccAcc,
    SelAccXt,
    SelAccOne
  } mm_sel_e;

  typedef enum logic [1:0] {
    MmIdle,
    MmRun,
    MmFinal
  } mm_state_e;

endpackage

// File: rtl/rsa_modexp_montgomery.sv
// Iterative radix-2 Montgomery multiplier: result = a * b * 2^-N mod m, for b < m and odd m.
// Consumes BitsPerCycle bits of a per clock, then one final conditional subtraction.
module rsa_modexp_montgomery
  import rsa_modexp_pkg::*;
#(
  parameter int unsigned N            = NDefault,
  parameter int unsigned BitsPerCycle = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] m,
  output logic [N-1:0] result,
  output logic         done
);

  localparam int unsigned Iters = N / BitsPerCycle;
  localparam int unsigned CntW  = (Iters > 1) ? $clog2(Iters) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Iters - 1);

  mm_state_e       st_q, st_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d, m_q, m_d, result_q, result_d;
  logic [N+1:0]    acc_q, acc_d, step, diff;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  // Partial sum stays below 2m, so N+2 bits hold acc + b + m without overflow.
  always_comb begin
    step = acc_q;
    for (int j = 0; j < BitsPerCycle; j++) begin
      if (a_q[j]) step = step + {2'b00, b_q};
      if (step[0]) step = step + {2'b00, m_q};
      step = step >> 1;
    end
    diff = acc_q - {2'b00, m_q};
  end

  always_comb begin
    st_d     = st_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (st_q)
      MmIdle: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          m_d   = m;
          acc_d = '0;
          cnt_d = '0;
          st_d  = MmRun;
        end
      end
      MmRun: begin
        acc_d = step;
        a_d   = a_q >> BitsPerCycle;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) st_d = MmFinal;
      end
      MmFinal: begin
        result_d = (acc_q >= {2'b00, m_q}) ? diff[N-1:0] : acc_q[N-1:0];
        done_d   = 1'b1;
        st_d     = MmIdle;
      end
      default: st_d = MmIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q     <= MmIdle;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: rtl/rsa_modexp.sv
// Left-to-right binary modular exponentiation, result = x^e mod m, sequencing one
// Montgomery product at a time. Caller supplies R mod m and R^2 mod m with R = 2^N.
module rsa_modexp
  import rsa_modexp_pkg::*;
#(
  parameter int unsigned N      = NDefault,
  parameter int unsigned ELEN_W = ElenWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N-1:0]      in_x,
  input  logic [N-1:0]      in_e,
  input  logic [ELEN_W-1:0] in_e_len,
  input  logic [N-1:0]      in_m,
  input  logic [N-1:0]      in_r_mod_m,
  input  logic [N-1:0]      in_r2_mod_m,
  output logic [N-1:0]      result,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IdxW = $clog2(N);
  localparam logic [ELEN_W-1:0] MaxLen = ELEN_W'(N);
  localparam logic [N-1:0] One = N'(1);

  state_e            state_q, state_d;
  logic [N-1:0]      x_q, x_d, e_q, e_d, m_q, m_d, r2_q, r2_d;
  logic [N-1:0]      acc_q, acc_d, xt_q, xt_d, result_q, result_d;
  logic [ELEN_W-1:0] idx_q, idx_d;

  mm_sel_e      mm_sel;
  logic         mm_start, mm_done, mm_resetn;
  logic [N-1:0] mm_a, mm_b, mm_result;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    e_d      = e_q;
    m_d      = m_q;
    r2_d     = r2_q;
    acc_d    = acc_q;
    xt_d     = xt_q;
    idx_d    = idx_q;
    result_d = result_q;
    mm_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = in_x;
          e_d     = in_e;
          m_d     = in_m;
          r2_d    = in_r2_mod_m;
          acc_d   = in_r_mod_m;
          idx_d   = (in_e_len > MaxLen) ? MaxLen : in_e_len;
          state_d = StPre;
        end
      end
      StPre: begin
        mm_start = 1'b1;
        state_d  = StPreWait;
      end
      StPreWait: begin
        if (mm_done) begin
          xt_d = mm_result;
          if (idx_q == '0) begin
            state_d = StPost;
          end else begin
            idx_d   = idx_q - ELEN_W'(1);
            state_d = StSq;
          end
        end
      end
      StSq: begin
        mm_start = 1'b1;
        state_d  = StSqWait;
      end
      StSqWait: begin
        if (mm_done) begin
          acc_d   = mm_result;
          state_d = e_q[idx_q[IdxW-1:0]] ? StMul : StLoopChk;
        end
      end
      StMul: begin
        mm_start = 1'b1;
        state_d  = StMulWait;
      end
      StMulWait: begin
        if (mm_done) begin
          acc_d   = mm_result;
          state_d = StLoopChk;
        end
      end
      StLoopChk: begin
        if (idx_q == '0) begin
          state_d = StPost;
        end else begin
          idx_d   = idx_q - ELEN_W'(1);
          state_d = StSq;
        end
      end
      StPost: begin
        mm_start = 1'b1;
        state_d  = StPostWait;
      end
      StPostWait: begin
        // Result is loaded with acc so it is already valid while done pulses.
        if (mm_done) begin
          acc_d    = mm_result;
          result_d = mm_result;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (state_q)
      StPre, StPreWait:   mm_sel = SelXR2;
      StMul, StMulWait:   mm_sel = SelAccXt;
      StPost, StPostWait: mm_sel = SelAccOne;
      default:            mm_sel = SelAccAcc;
    endcase
    case (mm_sel)
      SelXR2: begin
        mm_a = x_q;
        mm_b = r2_q;
      end
      SelAccXt: begin
        mm_a = acc_q;
        mm_b = xt_q;
      end
      SelAccOne: begin
        mm_a = acc_q;
        mm_b = One;
      end
      default: begin
        mm_a = acc_q;
        mm_b = acc_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      x_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      r2_q     <= '0;
      acc_q    <= '0;
      xt_q     <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      e_q      <= e_d;
      m_q      <= m_d;
      r2_q     <= r2_d;
      acc_q    <= acc_d;
      xt_q     <= xt_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  assign mm_resetn = ~reset;

  rsa_modexp_montgomery #(
    .N(N)
  ) u_montgomery (
    .clk   (clk),
    .resetn(mm_resetn),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .m     (m_q),
    .result(mm_result),
    .done  (mm_done)
  );

  assign busy   = (state_q != StIdle) && (state_q != StDone);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Scoreboard bench for rsa_modexp: expected x^e mod m from a shift-add reference model.
module tb_rsa_modexp;

  localparam int N  = 512;
  localparam int EW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  in_x = '0, in_e = '0, in_m = '0, in_r_mod_m = '0, in_r2_mod_m = '0;
  logic [EW-1:0] in_e_len = '0;
  logic [N-1:0]  result;
  logic          busy, done;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int mm_starts = 0;
  string cur_tag = "reset";
  logic [N-1:0] exp_q[$];

  rsa_modexp #(
    .N     (N),
    .ELEN_W(EW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_x       (in_x),
    .in_e       (in_e),
    .in_e_len   (in_e_len),
    .in_m       (in_m),
    .in_r_mod_m (in_r_mod_m),
    .in_r2_mod_m(in_r2_mod_m),
    .result     (result),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] pow2_mod(input logic [N-1:0] m, input int k);
    logic [N:0] r;
    r = (N+1)'(1);
    if (r >= {1'b0, m}) r = r - {1'b0, m};
    for (int i = 0; i < k; i++) begin
      r = r << 1;
      if (r >= {1'b0, m}) r = r - {1'b0, m};
    end
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] m);
    logic [N:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      r = r << 1;
      if (r >= {1'b0, m}) r = r - {1'b0, m};
      if (a[i]) r = r + {1'b0, b};
      if (r >= {1'b0, m}) r = r - {1'b0, m};
    end
    return r[N-1:0];
  endfunction

  // Right-to-left square-and-multiply over the low len bits of e.
  function automatic logic [N-1:0] powmod(input logic [N-1:0] x, input logic [N-1:0] e,
                                          input int len, input logic [N-1:0] m);
    logic [N-1:0] res, base;
    res  = pow2_mod(m, 0);
    base = x;
    for (int i = 0; i < len; i++) begin
      if (e[i]) res = mulmod(res, base, m);
      base = mulmod(base, base, m);
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (!reset && dut.mm_start) mm_starts++;
  end

  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) check_eq("spurious_done", N'(done), '0);
      else check_eq({cur_tag, "_result"}, result, exp_q.pop_front());
    end
  end

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] e, input logic [EW-1:0] len,
                        input logic [N-1:0] m);
    int eff;
    eff = (int'(len) > N) ? N : int'(len);
    @(posedge clk);
    #1;
    in_x        = x;
    in_e        = e;
    in_e_len    = len;
    in_m        = m;
    in_r_mod_m  = pow2_mod(m, N);
    in_r2_mod_m = pow2_mod(m, 2 * N);
    exp_q.push_back(powmod(x, e, eff, m));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke);
    bit seen, dropped;
    seen    = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check_eq({cur_tag, "_busy_at_done"}, N'(busy), '0);
        if (poke) start = 1'b1;
      end else if (!busy) begin
        dropped = 1'b1;
      end
    end
    check_eq({cur_tag, "_done_seen"}, N'(seen), N'(1));
    check_eq({cur_tag, "_busy_held"}, N'(dropped), '0);
    if (!seen) exp_q.delete();
    if (poke) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  initial begin
    logic [N-1:0] m241, e_fe, rnd_m, rnd_x, rnd_e;
    int s0, d0, busy_seen;
    bit reached;

    m241 = N'(241);
    e_fe = {N{1'b1}} ^ N'(1);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset_result", result, '0);
    check_eq("reset_busy", N'(busy), '0);
    check_eq("reset_done", N'(done), '0);

    cur_tag = "basic";
    d0 = done_cnt;
    run_op(N'(5), N'(3), EW'(2), m241);
    wait_done(2000, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("basic_done_count", N'(done_cnt - d0), N'(1));

    cur_tag = "mixed";
    s0 = mm_starts;
    run_op(N'(2), N'(13), EW'(4), m241);
    wait_done(2000, 1'b0);
    check_eq("mixed_mm_ops", N'(mm_starts - s0), N'(9));

    cur_tag = "elen0";
    s0 = mm_starts;
    run_op(N'(7), N'(5), EW'(0), m241);
    wait_done(2000, 1'b0);
    check_eq("elen0_mm_ops", N'(mm_starts - s0), N'(2));

    cur_tag = "short_e1";
    run_op(N'(7), N'(1), EW'(1), m241);
    wait_done(2000, 1'b0);
    cur_tag = "short_efe";
    run_op(N'(7), e_fe, EW'(1), m241);
    wait_done(2000, 1'b0);

    // Reset lands in the middle of the third Montgomery product.
    cur_tag = "reset_mid";
    s0 = mm_starts;
    reached = 1'b0;
    run_op(N'(5), N'(3), EW'(2), m241);
    for (int i = 0; i < 1000 && !reached; i++) begin
      @(negedge clk);
      if (mm_starts - s0 >= 3) reached = 1'b1;
    end
    check_eq("reset_mid_reached", N'(reached), N'(1));
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("reset_mid_busy", N'(busy), '0);
    check_eq("reset_mid_done", N'(done), '0);
    check_eq("reset_mid_result", result, '0);
    d0 = done_cnt;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (200) @(negedge clk);
    check_eq("no_done_after_reset", N'(done_cnt - d0), '0);

    cur_tag = "restart";
    run_op(N'(2), N'(13), EW'(4), m241);
    wait_done(2000, 1'b0);

    // Second start with a different base while busy, then a start during DONE.
    cur_tag = "start_busy";
    run_op(N'(5), N'(3), EW'(2), m241);
    repeat (40) @(negedge clk);
    #1 in_x = N'(9);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    d0 = done_cnt;
    wait_done(2000, 1'b1);
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check_eq("done_start_ignored", N'(busy_seen), '0);
    check_eq("start_busy_done_count", N'(done_cnt - d0), N'(1));

    cur_tag = "clamp";
    run_op(N'(3), N'(3), EW'(600), m241);
    wait_done(40000, 1'b0);

    cur_tag = "full";
    for (int i = 0; i < N / 32; i++) begin
      rnd_m[i*32 +: 32] = $urandom;
      rnd_x[i*32 +: 32] = $urandom;
      rnd_e[i*32 +: 32] = $urandom;
    end
    rnd_m[N-1] = 1'b1;
    rnd_m[0]   = 1'b1;
    rnd_x      = rnd_x % rnd_m;
    run_op(rnd_x, rnd_e, EW'(N), rnd_m);
    wait_done(60000, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
